// File: rtl/hamming_pkg.sv
// Shared (8,4) SECDED bit map and encoder function; the decoder imports the same positions.
// Optional error injection in the top is enabled by defining HAMMING_INYECCION_EN.
package hamming_pkg;

    typedef logic [7:0] palabra_t;
    typedef logic [3:0] nibble_t;

    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D0 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_PG = 7;

    function automatic palabra_t codificar(input nibble_t d);
        palabra_t w;
        w         = '0;
        w[POS_D0] = d[0];
        w[POS_D1] = d[1];
        w[POS_D2] = d[2];
        w[POS_D3] = d[3];
        w[POS_P1] = d[0] ^ d[1] ^ d[3];
        w[POS_P2] = d[0] ^ d[2] ^ d[3];
        w[POS_P4] = d[1] ^ d[2] ^ d[3];
        // Overall parity covers the seven Hamming bits, making the word even-weight.
        w[POS_PG] = ^w[6:0];
        return w;
    endfunction

endpackage

// File: rtl/codificador_hamming_fifo_palabras.sv
// PROF-deep synchronous codeword FIFO; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB compare.
module fifo_palabras #(
    parameter int PROF = 4,
    parameter int W    = 8,
    parameter int CW   = $clog2(PROF + 1)
) (
    input  logic          reloj,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  cabeza,
    output logic          lleno,
    output logic          vacio,
    output logic [CW-1:0] cuenta
);

    localparam int AW = $clog2(PROF);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [AW:0]  diff;
    logic [W-1:0] mem_q [PROF];
    logic         push_ok, pop_ok;

    assign vacio   = (wr_q == rd_q);
    assign lleno   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !lleno;
    assign pop_ok  = pop && !vacio;
    assign diff    = wr_q - rd_q;
    assign cuenta  = CW'(diff);
    assign cabeza  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge reloj or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: resetting the pointers already discards its contents.
    always_ff @(posedge reloj) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/codificador_hamming.sv
// SECDED (8,4) encoder with a codeword FIFO between two valid/ready handshakes.
// Define HAMMING_INYECCION_EN to add iny_mascara/iny_disparo error injection.
module codificador_hamming
    import hamming_pkg::*;
#(
    parameter int PROF   = 4,
    parameter int CONT_W = 16
) (
    input  logic                      reloj,
    input  logic                      rst,
    input  logic [3:0]                dato,
    input  logic                      dato_valido,
    output logic                      dato_listo,
    output logic [7:0]                palabra,
    output logic                      palabra_valida,
    input  logic                      palabra_lista,
`ifdef HAMMING_INYECCION_EN
    input  logic [7:0]                iny_mascara,
    input  logic                      iny_disparo,
`endif
    output logic [$clog2(PROF+1)-1:0] ocupacion,
    output logic [CONT_W-1:0]         enviadas
);

    palabra_t          cod_d;
    palabra_t          cabeza;
    logic              lleno, vacio;
    logic              push, pop;
    logic [CONT_W-1:0] enviadas_q, enviadas_d;

    always_comb begin
        cod_d = codificar(nibble_t'(dato));
`ifdef HAMMING_INYECCION_EN
        if (iny_disparo) cod_d = cod_d ^ iny_mascara;
`endif
    end

    // rst gating keeps the producer stalled while reset is held.
    assign dato_listo     = !lleno && !rst;
    assign palabra_valida = !vacio;
    assign palabra        = vacio ? 8'h00 : cabeza;
    assign push           = dato_valido && dato_listo;
    assign pop            = palabra_valida && palabra_lista;

    fifo_palabras #(
        .PROF (PROF),
        .W    (8)
    ) u_fifo (
        .reloj  (reloj),
        .rst    (rst),
        .push   (push),
        .din    (cod_d),
        .pop    (pop),
        .cabeza (cabeza),
        .lleno  (lleno),
        .vacio  (vacio),
        .cuenta (ocupacion)
    );

    always_comb begin
        enviadas_d = enviadas_q;
        if (pop) enviadas_d = enviadas_q + 1'b1;
    end

    always_ff @(posedge reloj or posedge rst) begin
        if (rst) enviadas_q <= '0;
        else     enviadas_q <= enviadas_d;
    end

    assign enviadas = enviadas_q;

endmodule

// File: tb/tb_codificador_hamming.sv
// Randomized and directed checks of codificador_hamming against a queue model
// whose codewords come from the textbook Hamming position rules.
module tb_codificador_hamming;

    localparam int PROF   = 4;
    localparam int CONT_W = 4;
`ifdef HAMMING_INYECCION_EN
    localparam bit INY = 1'b1;
`else
    localparam bit INY = 1'b0;
`endif

    logic        reloj = 1'b0;
    logic        rst;
    logic [3:0]  dato;
    logic        dato_valido;
    logic        dato_listo;
    logic [7:0]  palabra;
    logic        palabra_valida;
    logic        palabra_lista;
    logic [7:0]  iny_mascara;
    logic        iny_disparo;
    logic [2:0]  ocupacion;
    logic [3:0]  enviadas;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  q [$];
    int          sent = 0;

    always #5 reloj = ~reloj;

    codificador_hamming #(.PROF(PROF), .CONT_W(CONT_W)) dut (
        .reloj          (reloj),
        .rst            (rst),
        .dato           (dato),
        .dato_valido    (dato_valido),
        .dato_listo     (dato_listo),
        .palabra        (palabra),
        .palabra_valida (palabra_valida),
        .palabra_lista  (palabra_lista),
`ifdef HAMMING_INYECCION_EN
        .iny_mascara    (iny_mascara),
        .iny_disparo    (iny_disparo),
`endif
        .ocupacion      (ocupacion),
        .enviadas       (enviadas)
    );

    // Hamming positions are 1-based: data at 3,5,6,7; parity 2^k covers positions with bit k set.
    function automatic logic [7:0] ref_enc(input logic [3:0] d);
        logic [7:0] w;
        int         dpos [4];
        int         ones;
        logic       par;
        dpos = '{3, 5, 6, 7};
        w = 8'h00;
        for (int i = 0; i < 4; i++) w[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 7; p++) if (((p >> k) & 1) == 1) par = par ^ w[p-1];
            w[(1 << k) - 1] = par;
        end
        ones = 0;
        for (int p = 0; p < 7; p++) ones += int'(w[p]);
        w[7] = (ones % 2) == 1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        chk("dato_listo", {31'd0, dato_listo}, {31'd0, q.size() < PROF});
        chk("palabra_valida", {31'd0, palabra_valida}, {31'd0, q.size() > 0});
        chk("palabra", {24'd0, palabra}, {24'd0, head});
        chk("ocupacion", {29'd0, ocupacion}, q.size());
        chk("enviadas", {28'd0, enviadas}, sent % (1 << CONT_W));
    endtask

    // One clock: drive, check pre-edge outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [3:0] d, input logic l);
        logic       push, pop;
        logic [7:0] w, tmp;
        dato_valido = v; dato = d; palabra_lista = l;
        #2;
        check_outs();
        push = v && (q.size() < PROF);
        pop  = l && (q.size() > 0);
        w = ref_enc(d);
        if (INY && iny_disparo) w = w ^ iny_mascara;
        @(posedge reloj);
        if (pop) begin tmp = q.pop_front(); sent++; end
        if (push) q.push_back(w);
        #1;
    endtask

    task automatic enc1(input logic [3:0] d, input logic [7:0] exp, input string tag);
        cycle(1'b1, d, 1'b1);
        chk(tag, {24'd0, palabra}, {24'd0, exp});
        chk({tag, "_valid"}, {31'd0, palabra_valida}, 32'd1);
        cycle(1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; dato = 4'h0; dato_valido = 1'b0; palabra_lista = 1'b0;
        iny_mascara = 8'h00; iny_disparo = 1'b0;
        #2;
        chk("rst_listo", {31'd0, dato_listo}, 32'd0);
        chk("rst_valida", {31'd0, palabra_valida}, 32'd0);
        chk("rst_palabra", {24'd0, palabra}, 32'd0);
        chk("rst_enviadas", {28'd0, enviadas}, 32'd0);
        @(posedge reloj); #1;
        rst = 1'b0;
        #1 chk("post_rst_listo", {31'd0, dato_listo}, 32'd1);

        enc1(4'h0, 8'h00, "enc_0");
        enc1(4'hB, 8'h55, "enc_B");
        enc1(4'hF, 8'hFF, "enc_F");
        enc1(4'h1, 8'h87, "enc_1");
        chk("enviadas_4", {28'd0, enviadas}, 32'd4);

        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 3), 1'b0);
        chk("full_ocup", {29'd0, ocupacion}, 32'd4);
        chk("full_listo", {31'd0, dato_listo}, 32'd0);
        cycle(1'b1, 4'hE, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1);
        chk("drained_valida", {31'd0, palabra_valida}, 32'd0);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        while (q.size() > 0) cycle(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valida", {31'd0, palabra_valida}, 32'd0);
        chk("mid_rst_ocup", {29'd0, ocupacion}, 32'd0);
        chk("mid_rst_enviadas", {28'd0, enviadas}, 32'd0);
        chk("mid_rst_listo", {31'd0, dato_listo}, 32'd0);
        q.delete();
        sent = 0;
        @(posedge reloj); #1;
        rst = 1'b0;
        #1 chk("mid_rst_post_listo", {31'd0, dato_listo}, 32'd1);
        enc1(4'hB, 8'h55, "post_rst_enc_B");

        rst = 1'b1; #2; q.delete(); sent = 0;
        @(posedge reloj); #1; rst = 1'b0; #1;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'(i), 1'b1);
            chk("stream_ocup", {29'd0, ocupacion}, 32'd1);
        end
        cycle(1'b1, 4'h9, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        chk("wrap_enviadas", {28'd0, enviadas}, 32'd1);
        chk("wrap_empty", {31'd0, palabra_valida}, 32'd0);

`ifdef HAMMING_INYECCION_EN
        iny_disparo = 1'b1; iny_mascara = 8'h04;
        enc1(4'hB, 8'h51, "iny_single");
        iny_mascara = 8'h14;
        enc1(4'hB, 8'h41, "iny_double");
        iny_disparo = 1'b0;
        enc1(4'hB, 8'h55, "iny_off");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/codificador_hamming.md
Name: codificador_hamming

Overview:
- Sequential SECDED Hamming encoder; the transmit end of the (8,4) link whose receive side checks syndromes s1/s2/s3 and overall parity st.
- Accepts 4-bit data nibbles over a valid/ready handshake and encodes each into an 8-bit codeword.
- Buffers codewords in a small FIFO and presents them over a second valid/ready handshake to the channel or decoder.

Parameters:
- PROF, 4, FIFO depth in codewords (power of two, >=2).
- CONT_W, 16, width of the sent-codeword counter.

Ports:
- reloj  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- dato  input  4  data nibble d[3:0].
- dato_valido  input  1  producer presents dato.
- dato_listo  output  1  encoder can accept a nibble this cycle.
- palabra  output  8  codeword at FIFO head.
- palabra_valida  output  1  palabra is valid.
- palabra_lista  input  1  consumer accepts palabra this cycle.
- ocupacion  output  $clog2(PROF+1)  number of stored codewords.
- enviadas  output  CONT_W  codewords delivered since reset; wraps.

Behaviour:
- Bit mapping (fixed, must match decoder):
  - [2]=d0, [4]=d1, [5]=d2, [6]=d3.
  - [0]=d0^d1^d3, [1]=d0^d2^d3, [3]=d1^d2^d3.
  - [7]=XOR of bits [6:0] (even overall parity).
- Push:
  - Occurs when dato_valido && dato_listo.
  - dato_listo = !lleno. It is a registered-state function only, with no combinational path from palabra_lista.
  - Encoding is combinational on dato and written into the FIFO tail at the clock edge.
- Pop: occurs when palabra_valida && palabra_lista; the head pointer advances.
- Outputs:
  - palabra_valida = !vacio.
  - palabra is held at 8'h00 while !palabra_valida.
  - palabra and palabra_valida remain stable while palabra_valida && !palabra_lista.
- Latency: a nibble pushed at edge N appears on palabra with palabra_valida=1 after edge N when the FIFO was empty. There is no combinational in-to-out bypass.
- Simultaneous push and pop:
  - Both occur in the same cycle; ocupacion is unchanged.
  - When not empty, order is preserved: the old head goes out and the new word enters the tail.
- Full: dato_listo=0; dato is ignored even if dato_valido=1.
- Empty: a pop is impossible because palabra_valida=0.
- Pointer wrap: pointers are $clog2(PROF)+1 bits; full/empty are decided by the MSB compare.
- enviadas increments by 1 per pop and wraps 2^CONT_W-1 -> 0.
- Reset values (asynchronous, immediate on rst=1, including mid-transfer):
  - Pointers and ocupacion = 0; stored words are discarded.
  - enviadas = 0, palabra_valida = 0, palabra = 8'h00, dato_listo = 0 while rst=1.
  - dato_listo = 1 on the first cycle after rst deasserts.

Optional Feature:
- Macro: HAMMING_INYECCION_EN.
- Defined:
  - Adds input iny_mascara[7:0] and input iny_disparo (1 bit).
  - On a push with iny_disparo=1, the stored codeword is encoded XOR iny_mascara.
  - One set bit produces a single error; two set bits produce a double error at the decoder.
  - Used for link/decoder self-test.
- Not defined: ports absent; codewords are always clean.

Decomposition:
- Package hamming_pkg:
  - typedef palabra_t (logic [7:0]) and nibble_t (logic [3:0]).
  - Localparams for data and parity bit positions.
  - Function codificar(nibble_t) returning palabra_t.
  - The decoder later imports the same constants.
- Sub-module fifo_palabras: parameterized PROF×8 synchronous FIFO with full, empty and count outputs.
- codificador_hamming holds the handshake logic, encoding, the counter and the optional injection.

Test Plan:
- Single encodes, each with palabra_lista=1:
  - dato=4'h0 -> 8'h00.
  - dato=4'hB -> 8'h55.
  - dato=4'hF -> 8'hFF.
  - dato=4'h1 -> 8'h87.
  - Each appears one cycle after push; enviadas then reads 4.
- Backpressure:
  - Hold palabra_lista=0 and push 5 nibbles (PROF=4).
  - Fifth is refused (dato_listo=0, ocupacion=4).
  - Release palabra_lista: 4 words exit in order, then palabra_valida=0.
- Streaming: dato_valido=1 and palabra_lista=1 continuously over all 16 nibbles -> one codeword per cycle after the first; ocupacion stays 1.
- Reset mid-operation:
  - Fill 3 words, assert rst for 1 cycle.
  - Immediately palabra_valida=0, ocupacion=0, enviadas=0.
  - Next push of 4'hB yields 8'h55.
- Counter wrap: CONT_W=4, 17 pops -> enviadas=1.
- With HAMMING_INYECCION_EN, dato=4'hB:
  - iny_mascara=8'h04 -> 8'h51.
  - iny_mascara=8'h14 -> 8'h41.
  - iny_disparo=0 -> 8'h55.
